// File: rtl/dram_cmd_pkg.sv
// Shared types and constants for the DRAM command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, pin-level command encodings packed as
// {RASn, CASn, WEn[3:0]}, request address field positions and widths.
package dram_cmd_pkg;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int ROW_W   = 11;
    localparam int ROW_LSB = 12;
    localparam int COL_W   = 10;
    localparam int COL_LSB = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        PRE_WAIT = 3'd2,
        ACT      = 3'd3,
        ACT_WAIT = 3'd4,
        CAS      = 3'd5,
        RD_WAIT  = 3'd6,
        WR_WAIT  = 3'd7
    } state_t;

    // {RASn, CASn, WEn[3:0]}, CSn is held low throughout
    typedef logic [5:0] cmd_t;

    localparam cmd_t CMD_NOP  = 6'b11_1111;
    localparam cmd_t CMD_ACT  = 6'b01_1111;
    localparam cmd_t CMD_READ = 6'b10_1111;
    localparam cmd_t CMD_PRE  = 6'b01_0000;

    // WRITE carries the byte enables inverted onto the per-byte WEn pins
    function automatic cmd_t cmd_write(input logic [STRB_W-1:0] wstrb);
        return {2'b10, ~wstrb};
    endfunction

endpackage

// File: rtl/dram_delay_timer.sv
// Loadable down-counter with zero flag for DRAM timing waits.
// Latency: loaded value is visible the cycle after i_load; decrements 1/cycle.
// Backpressure: none; holds at zero until reloaded.
//
// Ports: i_clk/i_rst_n clock and async active-low reset, i_load/i_load_val
// load strobe and value, o_zero high while the count is zero.
module dram_delay_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dram_cmd_ctrl.sv
// Single-beat DRAM command sequencer: one read/write request -> ACT/READ/WRITE/PRE pins.
// Latency: hit write 2+T_WR; closed-row read 2+T_RCD+DRAM delay; conflict adds 1+T_RP.
// Backpressure: req_ready only in IDLE with the one-entry response buffer empty.
//
// Ports: dram_clk/dram_rst clock and async active-low reset; req_* request
// channel (valid/ready); rsp_* response channel (valid/ready); DRAM_* pins.
// Open-row policy: the last activated row stays open until a different row
// is requested. No refresh, no auto-precharge.
module dram_cmd_ctrl
    import dram_cmd_pkg::*;
#(
    parameter int T_RCD = 5,
    parameter int T_RP  = 5,
    parameter int T_WR  = 5,
    parameter int CNT_W = 4
) (
    input  logic              dram_clk,
    input  logic              dram_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              DRAM_CSn,
    output logic              DRAM_RASn,
    output logic              DRAM_CASn,
    output logic [STRB_W-1:0] DRAM_WEn,
    output logic [ROW_W-1:0]  DRAM_A,
    output logic [DATA_W-1:0] DRAM_D,
    input  logic [DATA_W-1:0] DRAM_Q,
    input  logic              DRAM_valid
);

    // Timer is loaded with N-1 in the command cycle so the wait state
    // lasts exactly N cycles (zero exits on the cycle it is seen).
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_WR - 1);

    state_t              r_state;
    logic                r_row_open;
    logic [ROW_W-1:0]    r_open_row;
    logic                r_write;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic                w_accept;
    logic [ROW_W-1:0]    w_req_row;
    logic [COL_W-1:0]    w_req_col;
    logic                w_unused_addr;
    logic                w_tmr_load;
    logic [CNT_W-1:0]    w_tmr_val;
    logic                w_tmr_zero;
    cmd_t                w_cmd;
    logic [ROW_W-1:0]    w_a;
    logic [DATA_W-1:0]   w_d;

    assign w_req_row     = req_addr[ROW_LSB +: ROW_W];
    assign w_req_col     = req_addr[COL_LSB +: COL_W];
    // byte offset within the word is not used by a word-wide device
    assign w_unused_addr = ^req_addr[COL_LSB-1:0];

    // Gated by reset so the upstream sees no ready while held in reset
    assign req_ready = dram_rst && (r_state == IDLE) && !r_rsp_valid;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            PRE: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = LD_RP;
            end
            ACT: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = LD_RCD;
            end
            CAS: begin
                w_tmr_load = r_write;
                w_tmr_val  = LD_WR;
            end
            default: ;
        endcase
    end

    dram_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (dram_clk),
        .i_rst_n    (dram_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge dram_clk or negedge dram_rst) begin
        if (!dram_rst) begin
            r_state     <= IDLE;
            r_row_open  <= 1'b0;
            r_open_row  <= '0;
            r_write     <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_row   <= w_req_row;
                        r_col   <= w_req_col;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        if (r_row_open && (w_req_row == r_open_row)) begin
                            r_state <= CAS;
                        end else if (!r_row_open) begin
                            r_state <= ACT;
                        end else begin
                            r_state <= PRE;
                        end
                    end
                end
                PRE: begin
                    r_row_open <= 1'b0;
                    r_state    <= PRE_WAIT;
                end
                PRE_WAIT: begin
                    if (w_tmr_zero) begin
                        r_state <= ACT;
                    end
                end
                ACT: begin
                    r_open_row <= r_row;
                    r_row_open <= 1'b1;
                    r_state    <= ACT_WAIT;
                end
                ACT_WAIT: begin
                    if (w_tmr_zero) begin
                        r_state <= CAS;
                    end
                end
                CAS: begin
                    r_state <= r_write ? WR_WAIT : RD_WAIT;
                end
                RD_WAIT: begin
                    if (DRAM_valid) begin
                        r_rsp_rdata <= DRAM_Q;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (w_tmr_zero) begin
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pins are decoded from the current state; only command states leave NOP
    always_comb begin
        w_cmd = CMD_NOP;
        w_a   = '0;
        w_d   = '0;
        case (r_state)
            PRE: w_cmd = CMD_PRE;
            ACT: begin
                w_cmd = CMD_ACT;
                w_a   = r_row;
            end
            CAS: begin
                w_cmd = r_write ? cmd_write(r_wstrb) : CMD_READ;
                w_a   = {{(ROW_W-COL_W){1'b0}}, r_col};
                w_d   = r_write ? r_wdata : '0;
            end
            default: ;
        endcase
    end

    assign DRAM_CSn  = 1'b0;
    assign DRAM_RASn = w_cmd[5];
    assign DRAM_CASn = w_cmd[4];
    assign DRAM_WEn  = w_cmd[3:0];
    assign DRAM_A    = w_a;
    assign DRAM_D    = w_d;

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dram_cmd_ctrl.sv
// Testbench for dram_cmd_ctrl: scoreboarded responses plus a pin-command log.
// Latency: n/a.
// Backpressure: exercises held rsp_ready with a pending request.
module tb_dram_cmd_ctrl;
    import dram_cmd_pkg::*;

    localparam int T_RCD = 5;
    localparam int T_RP  = 5;
    localparam int T_WR  = 5;
    localparam logic [48:0] PINS_NOP = {6'b11_1111, 11'd0, 32'd0};

    logic        dram_clk;
    logic        dram_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [22:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        DRAM_CSn;
    logic        DRAM_RASn;
    logic        DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q;
    logic        DRAM_valid;

    dram_cmd_ctrl #(
        .T_RCD (T_RCD),
        .T_RP  (T_RP),
        .T_WR  (T_WR),
        .CNT_W (4)
    ) dut (
        .dram_clk   (dram_clk),
        .dram_rst   (dram_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .DRAM_CSn   (DRAM_CSn),
        .DRAM_RASn  (DRAM_RASn),
        .DRAM_CASn  (DRAM_CASn),
        .DRAM_WEn   (DRAM_WEn),
        .DRAM_A     (DRAM_A),
        .DRAM_D     (DRAM_D),
        .DRAM_Q     (DRAM_Q),
        .DRAM_valid (DRAM_valid)
    );

    initial dram_clk = 1'b0;
    always #5 dram_clk = ~dram_clk;

    int cyc = 0;
    always @(posedge dram_clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- pin command log ----------------
    typedef struct {
        int          cyc;
        logic [48:0] pins;
    } ev_t;
    ev_t cmd_log[$];

    function automatic logic [48:0] pins_now();
        return {DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D};
    endfunction

    function automatic logic [48:0] mk_pins(input logic [5:0] c, input logic [10:0] a,
                                            input logic [31:0] d);
        return {c, a, d};
    endfunction

    always @(negedge dram_clk) begin
        ev_t e;
        if (pins_now() != PINS_NOP) begin
            e.cyc  = cyc;
            e.pins = pins_now();
            cmd_log.push_back(e);
        end
    end

    function automatic logic [48:0] cmd_at(input int i);
        if (i < cmd_log.size()) return cmd_log[i].pins;
        return '1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < cmd_log.size()) return cmd_log[i].cyc;
        return -1000;
    endfunction

    // ---------------- DRAM read responder: Q valid 3 cycles after READ ----------------
    logic [31:0] rdq[$];

    initial begin
        logic [31:0] d;
        DRAM_valid = 1'b0;
        DRAM_Q     = '0;
        forever begin
            @(negedge dram_clk);
            if (dram_rst && DRAM_RASn && !DRAM_CASn && DRAM_WEn == 4'hF && rdq.size() > 0) begin
                d = rdq.pop_front();
                repeat (3) @(posedge dram_clk);
                #1;
                DRAM_valid = 1'b1;
                DRAM_Q     = d;
                @(posedge dram_clk);
                #1;
                DRAM_valid = 1'b0;
                DRAM_Q     = '0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [31:0] d;
    } rsp_t;
    rsp_t exp_q[$];

    int acc_cyc;
    int rsp_cyc;

    task automatic drive_req(input logic w, input logic [22:0] a, input logic [31:0] wd,
                             input logic [3:0] ws);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
    endtask

    // Called at a negedge with a request driven; q is the DRAM data for a read
    task automatic wait_accept(input string tag, input logic [31:0] q);
        int   n;
        rsp_t e;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge dram_clk);
            n++;
        end
        if (!req_ready) begin
            chk({tag, "_accept_timeout"}, 64'(0), 64'(1));
            req_valid = 1'b0;
            return;
        end
        e.wr = req_write;
        e.d  = req_write ? 32'h0 : q;
        exp_q.push_back(e);
        if (!req_write) rdq.push_back(q);
        @(negedge dram_clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int   n;
        rsp_t e;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge dram_clk);
            n++;
        end
        if (!rsp_valid) begin
            chk({tag, "_rsp_timeout"}, 64'(0), 64'(1));
            return;
        end
        rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rsp_write"}, 64'(rsp_write), 64'(e.wr));
            chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(e.d));
        end
        rsp_ready = 1'b1;
        @(negedge dram_clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        dram_rst  = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge dram_clk);

        // reset values
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_write", 64'(rsp_write), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_pins", 64'(pins_now()), 64'(PINS_NOP));
        chk("rst_csn", 64'(DRAM_CSn), 64'(0));
        dram_rst = 1'b1;
        @(negedge dram_clk);

        // 1: read from closed row 1 col 1
        cmd_log.delete();
        drive_req(1'b0, 23'h001004, 32'h0, 4'h0);
        wait_accept("t1", 32'hDEADBEEF);
        wait_rsp("t1");
        chk("t1_ncmd", 64'(cmd_log.size()), 64'(2));
        chk("t1_act", 64'(cmd_at(0)), 64'(mk_pins(CMD_ACT, 11'd1, 32'h0)));
        chk("t1_read", 64'(cmd_at(1)), 64'(mk_pins(CMD_READ, 11'd1, 32'h0)));
        chk("t1_act_lat", 64'(cyc_at(0) - acc_cyc), 64'(0));
        chk("t1_trcd", 64'(cyc_at(1) - cyc_at(0)), 64'(T_RCD + 1));
        chk("t1_rd_lat", 64'(rsp_cyc - cyc_at(1)), 64'(4));

        // 2: row-hit write, partial strobes
        cmd_log.delete();
        drive_req(1'b1, 23'h001008, 32'h12345678, 4'b0101);
        wait_accept("t2", 32'h0);
        wait_rsp("t2");
        chk("t2_ncmd", 64'(cmd_log.size()), 64'(1));
        chk("t2_write", 64'(cmd_at(0)), 64'(mk_pins({2'b10, 4'b1010}, 11'd2, 32'h12345678)));
        chk("t2_cas_lat", 64'(cyc_at(0) - acc_cyc), 64'(0));
        chk("t2_twr", 64'(rsp_cyc - cyc_at(0)), 64'(T_WR + 1));

        // 3: row conflict read; 4: pending request while response is held
        cmd_log.delete();
        drive_req(1'b0, 23'h002000, 32'h0, 4'h0);
        wait_accept("t3", 32'hCAFEF00D);
        drive_req(1'b0, 23'h002014, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge dram_clk);
            n++;
        end
        chk("t3_rsp_seen", 64'(rsp_valid), 64'(1));
        chk("t3_ncmd", 64'(cmd_log.size()), 64'(3));
        chk("t3_pre", 64'(cmd_at(0)), 64'(mk_pins(CMD_PRE, 11'd0, 32'h0)));
        chk("t3_act", 64'(cmd_at(1)), 64'(mk_pins(CMD_ACT, 11'd2, 32'h0)));
        chk("t3_read", 64'(cmd_at(2)), 64'(mk_pins(CMD_READ, 11'd0, 32'h0)));
        chk("t3_trp", 64'(cyc_at(1) - cyc_at(0)), 64'(T_RP + 1));
        chk("t3_trcd", 64'(cyc_at(2) - cyc_at(1)), 64'(T_RCD + 1));
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", 64'(rsp_valid), 64'(1));
            chk("t4_hold_rdata", 64'(rsp_rdata), 64'(32'hCAFEF00D));
            chk("t4_hold_req_ready", 64'(req_ready), 64'(0));
            chk("t4_hold_pins", 64'(pins_now()), 64'(PINS_NOP));
            @(negedge dram_clk);
        end
        wait_rsp("t3");
        chk("t4_rsp_cleared", 64'(rsp_valid), 64'(0));
        chk("t4_req_ready", 64'(req_ready), 64'(1));
        cmd_log.delete();
        wait_accept("t4", 32'h0BADF00D);
        wait_rsp("t4");
        chk("t4_ncmd", 64'(cmd_log.size()), 64'(1));
        chk("t4_read", 64'(cmd_at(0)), 64'(mk_pins(CMD_READ, 11'd5, 32'h0)));

        // 5: reset during ACT_WAIT closes the row
        cmd_log.delete();
        drive_req(1'b0, 23'h003010, 32'h0, 4'h0);
        wait_accept("t5a", 32'h55AA55AA);
        n = 0;
        while (cmd_log.size() < 2 && n < 200) begin
            @(negedge dram_clk);
            n++;
        end
        chk("t5_act_before_rst", 64'(cmd_at(1)), 64'(mk_pins(CMD_ACT, 11'd3, 32'h0)));
        repeat (2) @(negedge dram_clk);
        #2;
        dram_rst = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("t5_rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("t5_rst_req_ready", 64'(req_ready), 64'(0));
        chk("t5_rst_pins", 64'(pins_now()), 64'(PINS_NOP));
        exp_q.delete();
        rdq.delete();
        @(negedge dram_clk);
        dram_rst = 1'b1;
        @(negedge dram_clk);
        cmd_log.delete();
        drive_req(1'b0, 23'h003010, 32'h0, 4'h0);
        wait_accept("t5", 32'h13579BDF);
        wait_rsp("t5");
        chk("t5_ncmd", 64'(cmd_log.size()), 64'(2));
        chk("t5_act", 64'(cmd_at(0)), 64'(mk_pins(CMD_ACT, 11'd3, 32'h0)));
        chk("t5_read", 64'(cmd_at(1)), 64'(mk_pins(CMD_READ, 11'd4, 32'h0)));

        // 6: write with no byte enables to the open row
        cmd_log.delete();
        drive_req(1'b1, 23'h00301C, 32'hA5A5A5A5, 4'b0000);
        wait_accept("t6", 32'h0);
        wait_rsp("t6");
        chk("t6_ncmd", 64'(cmd_log.size()), 64'(1));
        chk("t6_write", 64'(cmd_at(0)), 64'(mk_pins({2'b10, 4'hF}, 11'd7, 32'hA5A5A5A5)));
        chk("t6_twr", 64'(rsp_cyc - cyc_at(0)), 64'(T_WR + 1));

        repeat (2) @(negedge dram_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cmd_ctrl.md
Name: dram_cmd_ctrl

Overview:
- Single-beat command sequencer between the DRAM-side AXI slave wrapper (upstream) and the external DRAM pins (downstream).
- Accepts one read or write word request at a time over a valid/ready interface.
- Translates each request into ACT/READ/WRITE/PRE pin sequences with parameterised timing and an open-row policy.
- Returns read data or a write acknowledgement through a one-entry response buffer.

Parameters:
T_RCD  5  cycles from ACT issue to the first cycle a READ/WRITE may issue (min 1)
T_RP   5  cycles from PRE issue until ACT may issue (min 1)
T_WR   5  cycles after WRITE issue before the write response and the next command (min 1)
CNT_W  4  timer counter width; must hold max(T_RCD,T_RP,T_WR)

Ports:
dram_clk    in   1   clock
dram_rst    in   1   asynchronous reset, active-low
req_valid   in   1   request valid
req_ready   out  1   request accepted when valid&ready
req_write   in   1   1=write, 0=read
req_addr    in   23  byte address; row=[22:12], col=[11:2], [1:0] ignored
req_wdata   in   32  write data
req_wstrb   in   4   byte enables, active-high
rsp_valid   out  1   response valid
rsp_ready   in   1   response consumed when valid&ready
rsp_write   out  1   1=write ack, 0=read data
rsp_rdata   out  32  read data (0 for write ack)
DRAM_CSn    out  1   chip select, active-low
DRAM_RASn   out  1   row strobe, active-low
DRAM_CASn   out  1   column strobe, active-low
DRAM_WEn    out  4   per-byte write enable, active-low
DRAM_A      out  11  row address on ACT; {1'b0,col} on READ/WRITE
DRAM_D      out  32  write data
DRAM_Q      in   32  read data
DRAM_valid  in   1   DRAM_Q valid this cycle

Behaviour:
- Command encodings {RASn,CASn,WEn} with CSn=0: NOP={1,1,F}; ACT={0,1,F}; READ={1,0,F}; WRITE={1,0,~wstrb}; PRE={0,1,0}. Outside a command cycle all pins are NOP; DRAM_A and DRAM_D are 0.
- Reset (async, dram_rst=0): state IDLE, row_open=0, open_row=0, timer=0; req_ready=0 during reset; rsp_valid=0, rsp_write=0, rsp_rdata=0; pins at NOP.
- req_ready=1 only in IDLE with rsp_valid=0. A request is captured into registers on valid&ready.
- FSM:
  - IDLE: on accept, row hit (row_open & row==open_row) -> CAS; row_open=0 -> ACT; else -> PRE.
  - PRE: one cycle driving PRE; row_open<=0; load timer=T_RP-1; -> PRE_WAIT.
  - PRE_WAIT: NOP until timer==0 -> ACT.
  - ACT: one cycle driving ACT with A=row; open_row<=row, row_open<=1; timer=T_RCD-1; -> ACT_WAIT.
  - ACT_WAIT: NOP until timer==0 -> CAS.
  - CAS: one cycle driving READ or WRITE. Read -> RD_WAIT. Write: timer=T_WR-1 -> WR_WAIT.
  - RD_WAIT: NOP until DRAM_valid=1; latch DRAM_Q into rsp_rdata, rsp_valid<=1, rsp_write<=0 -> IDLE.
  - WR_WAIT: NOP until timer==0; rsp_valid<=1, rsp_write<=1, rsp_rdata<=0 -> IDLE.
- The timer counts down one per cycle in wait states; a value of 0 exits on that cycle.
- Latency, accept to rsp_valid:
  - Row-hit write: 1 (CAS) + T_WR + 1.
  - Row-miss read from closed: 1 (ACT) + T_RCD + 1 (CAS) + DRAM read delay.
  - Conflict: add 1 + T_RP.
- rsp_valid holds, with stable data, until rsp_ready. It clears the cycle after the handshake, so the next request can be accepted the cycle after rsp clears.
- Rows stay open across requests; no auto-precharge and no refresh.
- DRAM_valid outside RD_WAIT is ignored.
- A write with wstrb=0 still issues WRITE with WEn=F and returns an ack.
- Reset mid-operation aborts the sequence immediately. Any pending response is dropped, and the row is treated as closed.

Decomposition:
- dram_cmd_pkg: state enum (IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CAS, RD_WAIT, WR_WAIT); command encoding constants (CMD_NOP/ACT/READ/PRE); row/col field widths and bit positions.
- One sub-module, dram_delay_timer: loadable down-counter with a zero flag, width CNT_W, same clock and reset.

Test Plan:
1. After reset, read addr 0x001004 (row 1, col 1); DRAM_valid 3 cycles after READ with Q=0xDEADBEEF -> ACT A=1, READ A=1 exactly T_RCD+1 cycles later, rsp_rdata=0xDEADBEEF, rsp_write=0.
2. Then write addr 0x001008, data 0x12345678, wstrb=4'b0101 -> no ACT/PRE; WRITE with A=2, WEn=4'b1010, D=0x12345678; ack T_WR+1 cycles after WRITE.
3. Then read addr 0x002000 (row 2) -> PRE (WEn=0), ACT A=2 after T_RP+1 cycles, then READ A=0.
4. Hold rsp_ready=0 for 10 cycles with req_valid=1 -> rsp_valid and rsp_rdata stable, req_ready=0, pins at NOP; one cycle after rsp_ready=1, req_ready=1.
5. Assert dram_rst low during ACT_WAIT -> outputs at reset values in the same cycle; the next request to the same row issues ACT (no hit).
6. Write with wstrb=0 to an open row -> WRITE with WEn=F, ack returned, rsp_rdata=0.
